// File: rtl/psp_checker.sv
// Self-synchronising receive checker for LFSR pseudo-random bit streams.
// Loads its history from the received bits, locks on a clean run, then counts bit errors.
module psp_checker #(
  parameter int                WIDTH  = 3,
  parameter logic [WIDTH-1:0]  TAPS   = 3'b111,
  parameter int unsigned       LOCK_N = 4,
  parameter int unsigned       LOSS_N = 8,
  parameter int                CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int FILL_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_FILL, ST_HUNT, ST_LOCKED} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   hist_reg, hist_next;
  logic [FILL_W-1:0]  fill_reg, fill_next;
  logic [7:0]         run_reg, run_next;
  logic               locked_reg, locked_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next;
  logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;

  logic [WIDTH-1:0]   tap_terms;
  logic               pred;
  logic               mism;
  logic [7:0]         run_inc;
  logic               err_inc;
  logic               bit_inc;

  // Predicted bit is the recurrence applied to the history before this bit shifts in.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tap_terms[gi] = TAPS[gi] & hist_reg[gi];
    end
  endgenerate

  assign pred    = ^tap_terms;
  assign mism    = in_valid & (in_bit != pred);
  assign run_inc = run_reg + 8'd1;

  always_comb begin
    state_next   = state_reg;
    hist_next    = hist_reg;
    fill_next    = fill_reg;
    run_next     = run_reg;
    locked_next  = locked_reg;
    err_next     = 1'b0;
    err_cnt_next = err_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    err_inc      = 1'b0;
    bit_inc      = 1'b0;

    if (in_valid) begin
      hist_next = {hist_reg[WIDTH-2:0], in_bit};
      case (state_reg)
        ST_FILL: begin
          if (fill_reg == FILL_W'(WIDTH - 1)) begin
            state_next = ST_HUNT;
            fill_next  = '0;
            run_next   = 8'd0;
          end else begin
            fill_next = fill_reg + FILL_W'(1);
          end
        end
        ST_HUNT: begin
          // An all-zero history trivially predicts zero, so it never counts toward lock.
          if ((hist_reg != '0) && !mism) begin
            if (run_inc == 8'(LOCK_N)) begin
              state_next  = ST_LOCKED;
              locked_next = 1'b1;
              run_next    = 8'd0;
            end else begin
              run_next = run_inc;
            end
          end else begin
            run_next = 8'd0;
          end
        end
        ST_LOCKED: begin
          bit_inc = 1'b1;
          if (mism) begin
            err_next = 1'b1;
            err_inc  = 1'b1;
            if (run_inc == 8'(LOSS_N)) begin
              state_next  = ST_HUNT;
              locked_next = 1'b0;
              run_next    = 8'd0;
            end else begin
              run_next = run_inc;
            end
          end else begin
            run_next = 8'd0;
          end
        end
        default: begin
          state_next = ST_FILL;
        end
      endcase
    end

    // Clear beats a coincident increment; counters stick at all-ones.
    if (clr_cnt) begin
      err_cnt_next = '0;
      bit_cnt_next = '0;
    end else begin
      if (err_inc && (err_cnt_reg != '1)) err_cnt_next = err_cnt_reg + CNT_W'(1);
      if (bit_inc && (bit_cnt_reg != '1)) bit_cnt_next = bit_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_FILL;
      hist_reg    <= '0;
      fill_reg    <= '0;
      run_reg     <= 8'd0;
      locked_reg  <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      hist_reg    <= hist_next;
      fill_reg    <= fill_next;
      run_reg     <= run_next;
      locked_reg  <= locked_next;
      err_reg     <= err_next;
      err_cnt_reg <= err_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign locked  = locked_reg;
  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;
  assign bit_cnt = bit_cnt_reg;

endmodule

// File: tb/tb_psp_checker.sv
// Directed bench for psp_checker: two instances (16-bit and 4-bit counters) share one stimulus
// stream so saturation is visible side by side with the unsaturated count.
module tb_psp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_bit, in_valid, clr_cnt;
  logic        locked16, err16, locked4, err4;
  logic [15:0] ec16, bc16;
  logic [3:0]  ec4, bc4;

  psp_checker #(.CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .locked(locked16), .err(err16), .err_cnt(ec16), .bit_cnt(bc16)
  );

  psp_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .locked(locked4), .err(err4), .err_cnt(ec4), .bit_cnt(bc4)
  );

  typedef struct {
    logic rst_n;
    logic v;
    logic b;
    logic clr;
    logic exp_l;
    logic exp_e;
    int   exp_ec;
    int   exp_bc;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int stepn = 0;
  logic [2:0] th;   // bits actually sent
  logic [2:0] ih;   // ideal generator history (flipped bits excluded)
  vec_t tbl [15];

  function automatic logic pred3(input logic [2:0] h);
    return ^h;
  endfunction

  function automatic int sat4(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, stepn, act, exp_v);
    end
  endtask

  task automatic check(input logic l, input logic e, input int ec, input int bc);
    $display("step %0d: rst=%0b v=%0b bit=%0b clr=%0b -> locked=%0b err=%0b err_cnt=%0d bit_cnt=%0d (w4 %0d/%0d)",
             stepn, rst, in_valid, in_bit, clr_cnt, locked16, err16, ec16, bc16, ec4, bc4);
    cmp("locked",     int'(locked16), int'(l));
    cmp("err",        int'(err16),    int'(e));
    cmp("err_cnt",    int'(ec16),     ec);
    cmp("bit_cnt",    int'(bc16),     bc);
    cmp("locked_w4",  int'(locked4),  int'(l));
    cmp("err_w4",     int'(err4),     int'(e));
    cmp("err_cnt_w4", int'(ec4),      sat4(ec));
    cmp("bit_cnt_w4", int'(bc4),      sat4(bc));
  endtask

  task automatic step(input logic r, input logic v, input logic b, input logic c);
    rst      = r;
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    stepn++;
    if (r && v) th = {th[1:0], b};
  endtask

  task automatic good(input logic c);
    logic b;
    b = pred3(ih);
    step(1'b1, 1'b1, b, c);
    ih = {ih[1:0], b};
  endtask

  task automatic flip();
    logic b;
    b = pred3(ih);
    step(1'b1, 1'b1, ~b, 1'b0);
    ih = {ih[1:0], b};
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    th = 3'b000; ih = 3'b000;

    // rst_n, v, b, clr, locked, err, err_cnt, bit_cnt
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 3};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 4};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 5};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[14].b = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst_n, tbl[i].v, tbl[i].b, tbl[i].clr);
      check(tbl[i].exp_l, tbl[i].exp_e, tbl[i].exp_ec, tbl[i].exp_bc);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check(1'b1, 1'b0, 0, 1);
    ih = th;

    // Single flipped bit: four consecutive error pulses, lock kept.
    good(1'b0);
    check(1'b1, 1'b0, 0, 2);
    for (int j = 0; j < 7; j++) begin
      if (j == 0) flip(); else good(1'b0);
      check(1'b1, (j < 4), (j < 4) ? j + 1 : 4, 3 + j);
    end

    // Eight inverted predictions drop lock on the eighth pulse.
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b1, ~pred3(th), 1'b0);
      ih = th;
      check((j < 7), 1'b1, 5 + j, 10 + j);
    end
    for (int j = 0; j < 4; j++) begin
      good(1'b0);
      check((j == 3), 1'b0, 12, 17);
    end

    // Valid gaps hold state; clear coinciding with an error yields zero.
    good(1'b0);                     check(1'b1, 1'b0, 12, 18);
    step(1'b1, 1'b0, 1'b0, 1'b0);   check(1'b1, 1'b0, 12, 18);
    good(1'b0);                     check(1'b1, 1'b0, 12, 19);
    step(1'b1, 1'b0, 1'b1, 1'b0);   check(1'b1, 1'b0, 12, 19);
    flip();                         check(1'b1, 1'b1, 13, 20);
    step(1'b1, 1'b0, 1'b0, 1'b0);   check(1'b1, 1'b0, 13, 20);
    good(1'b1);                     check(1'b1, 1'b1, 0, 0);
    good(1'b0);                     check(1'b1, 1'b1, 1, 1);
    good(1'b0);                     check(1'b1, 1'b1, 2, 2);
    good(1'b0);                     check(1'b1, 1'b0, 2, 3);

    // All-zero stream never locks.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check(1'b0, 1'b0, 0, 0);
    for (int j = 0; j < 50; j++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check(1'b0, 1'b0, 0, 0);
    end

    // Fresh lock, then 20 errors in spaced bursts to saturate the narrow counters.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check(1'b0, 1'b0, 0, 0);
    ih = 3'b001;
    for (int j = 0; j < 7; j++) begin
      good(1'b0);
      check((j == 6), 1'b0, 0, 0);
    end
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 5; j++) begin
        if (j == 0) flip(); else good(1'b0);
        check(1'b1, (j < 4), r * 4 + ((j < 4) ? j + 1 : 4), r * 5 + j + 1);
      end
    end

    // Mid-stream reset clears everything; relock after seven valid bits.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check(1'b0, 1'b0, 0, 0);
    for (int j = 0; j < 7; j++) begin
      good(1'b0);
      check((j == 6), 1'b0, 0, 0);
    end
    good(1'b0);
    check(1'b1, 1'b0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psp_checker.md
Name: psp_checker

Overview:
- Receive-side checker for the LFSR pseudo-random bit sequences produced by the team's PSP generators.
- Takes a serial bit stream with a valid qualifier and self-synchronises: its history register is loaded from the received bits themselves.
- Declares lock once the stream obeys the configured recurrence, then counts bit errors.
- Sits at the receiver end of a PSP link test (loopback or channel BER measurement).

Parameters:
- WIDTH, 3, LFSR length in bits (number of history bits), 2..16.
- TAPS, 3'b111, recurrence mask [WIDTH-1:0]. Bit k set means s(n-1-k) enters the XOR. Default matches s(n)=s(n-1)^s(n-2)^s(n-3).
- LOCK_N, 4, consecutive correct non-zero-history predictions required to assert lock, 1..255.
- LOSS_N, 8, consecutive mispredictions while locked that drop lock, 1..255.
- CNT_W, 16, width of error and bit counters.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst, input, 1, synchronous active-low reset.
- in_bit, input, 1, received PSP bit.
- in_valid, input, 1, in_bit is sampled on this clock edge.
- clr_cnt, input, 1, synchronous clear of err_cnt and bit_cnt; lock state is kept.
- locked, output, 1, checker is synchronised.
- err, output, 1, one-cycle pulse: the last valid bit mismatched while locked.
- err_cnt, output, CNT_W, saturating count of err pulses.
- bit_cnt, output, CNT_W, saturating count of valid bits checked while locked.

Behaviour:
- Reset (rst=0 at an edge): all outputs 0, hist=0, fill=0, run=0, state FILL. Reset has priority over every other input.
- hist[WIDTH-1:0]: hist[0] is the most recent valid bit. On every valid bit in every state, hist <= {hist[WIDTH-2:0], in_bit}. The received bit is always shifted in; the predicted bit is never used.
- pred = XOR over k of (TAPS[k] & hist[k]), computed from hist before the shift. mism = in_valid & (in_bit != pred).
- All outputs are registered and reflect a valid bit on the following cycle. With in_valid=0 all state holds and err=0.
- States:
  - FILL: count valid bits. After WIDTH valid bits, go to HUNT with run=0. No comparisons are made in FILL.
  - HUNT: on a valid bit with hist!=0 and no mismatch, run++. On a mismatch, run=0. With hist==0, run=0 (zero-lock guard: an all-zero stream never locks). When run reaches LOCK_N, go to LOCKED, set locked=1, run=0. The bit that completes LOCK_N is not counted in bit_cnt.
  - LOCKED: every valid bit increments bit_cnt. On a mismatch: err=1 next cycle, err_cnt++, run++. On a match: run=0. When run reaches LOSS_N, go to HUNT, locked=0, run=0. The LOSS_N-th error is still pulsed and counted.
- A single flipped line bit produces 1+popcount(TAPS) mismatches (error multiplication, inherent to self-sync). The default LOSS_N must exceed this.
- Counters saturate at all-ones and do not wrap.
- clr_cnt: counters load 0. If an increment occurs on the same edge, clear wins and the result is 0.
- Reset mid-stream returns to FILL. Lock is lost; resync needs WIDTH+LOCK_N valid bits.

Test Plan:
- Reset, then feed the defaults' generator stream 1,0,0,1,1,0,0,1,... with in_valid=1 every cycle. locked rises on the cycle after the 7th bit; err stays 0; bit_cnt=N-7 after N bits.
- Locked, flip one bit. Exactly 4 consecutive err pulses; err_cnt=4; locked stays 1.
- Locked, feed 8 consecutive inverted predictions (force in_bit=!pred). 8 err pulses, then locked=0 on the 8th pulse cycle; relock after 4 good non-zero bits.
- Constant 0 stream for 50 bits after reset: locked stays 0, err stays 0, counters stay 0.
- Locked with in_valid toggling 1,0,1,0: state holds on gaps, err never asserts on an invalid cycle. Then assert clr_cnt together with an error: err_cnt=0 the next cycle.
- Locked, pull rst low for 1 cycle mid-stream: all outputs 0 on the next cycle, FILL re-entered, lock reacquired 7 valid bits later. With CNT_W=4, force 20 errors: err_cnt holds at 15.
